move_request_gen: RTL
=====================

Name: move_request_gen

Overview:
- Initiator side of the grid-movement interface on the 8x8 board.
- Conditions four raw push buttons: debounce, then rising-edge detect.
- Turns each accepted press into a held direction request to the movement block.
- Waits for the movement block's validity response, then commits the returned next coordinates as the current position.

Parameters:
- COORD_W, 3, width of row/column coordinates (8x8 board).
- DEBOUNCE_CYCLES, 4, consecutive identical raw samples needed to change a debounced button level.
- RESP_TIMEOUT, 8, WAIT-state cycles allowed before a request counts as rejected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw active-high buttons, asynchronous to clk.
- load_en  in  1  force position load.
- load_i, load_j  in  COORD_W each  position value to load.
- inext, jnext  in  COORD_W each  next row/column from the movement block.
- mov_valid  in  1  movement block's movimientoValido.
- up, down, left, right  out  1 each  direction request to the movement block.
- iactual, jactual  out  COORD_W each  committed position; also feeds the movement block.
- busy  out  1  high in REQ, WAIT or DONE.
- rejected  out  1  one-cycle pulse on timeout.
- move_count  out  8  committed moves, saturating.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - All outputs 0; iactual=jactual=0; move_count=0.
  - Debounced levels, edge history and counters cleared; FSM=IDLE.
  - Same effect mid-request; any in-flight request is discarded.
- Debounce, per button:
  - 2-flop synchronizer, then counter.
  - Counter increments while synchronized raw != debounced level; clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Rise = debounced & ~debounced_d1, one cycle wide.
- Mask formation in IDLE, from the rise vector:
  - up&down both set -> both dropped; left&right both set -> both dropped.
  - Remaining mask may be orthogonal-only (see DIAGONAL_EN).
- FSM states:
  - IDLE: outputs up/down/left/right=0. If load_en: iactual/jactual load. Else if mask!=0: latch mask, go to REQ.
  - REQ, 1 cycle: direction outputs = latched mask. Clear timeout counter, go to WAIT.
  - WAIT: direction outputs stay held.
    - If mov_valid=1: iactual<=inext, jactual<=jnext, move_count+1 (saturate at 255), go to DONE.
    - Else timeout counter +1. On reaching RESP_TIMEOUT: rejected=1 for that cycle, position unchanged, go to DONE.
  - DONE, 1 cycle: direction outputs 0, go to IDLE.
- Latency: raw press stable from edge k. Debounced level goes high at edge k+2+DEBOUNCE_CYCLES. State=REQ with direction outputs high one edge later.
- Rises occurring outside IDLE are dropped, never queued.
- load_en in any non-reset state:
  - Loads the position and returns to IDLE.
  - Aborts any request without a rejected pulse.
  - move_count is unchanged.
- mov_valid outside WAIT is ignored.
- mov_valid in the same cycle as the timeout reaching RESP_TIMEOUT: valid wins.
- A held button produces exactly one request. A new request needs a debounced release, then a new press.

Optional Feature:
- DIAGONAL_EN defined:
  - After opposing-pair cancellation, one vertical plus one horizontal bit is issued as a diagonal request, e.g. up+left together.
- DIAGONAL_EN undefined:
  - Only the highest-priority remaining bit is kept, priority up > down > left > right.
  - Example: up+left -> up only.

Test Plan:
- Reset, then btn_right stable for 10 cycles; model returns mov_valid=1, inext=0, jnext=1 -> right held through REQ/WAIT; iactual=0, jactual=1; move_count=1.
- btn_down glitch of 2 cycles (< DEBOUNCE_CYCLES=4) -> no request; busy stays 0.
- load_en with load_i=7, load_j=7, then btn_up; model returns mov_valid=1, inext=6, jnext=7 -> iactual=6, jactual=7; move_count increments.
- btn_left pressed, model never asserts mov_valid -> rejected pulses once, 8 cycles after WAIT entry; position unchanged; FSM returns to IDLE.
- btn_left and btn_up rising in the same cycle from position 7,7:
  - DIAGONAL_EN defined -> up=left=1; model returns 6,6 -> position 6,6.
  - DIAGONAL_EN undefined -> only up=1.
- btn_up and btn_down together -> no request. rst asserted during WAIT -> all outputs 0, position 0,0 on the next cycle.

Source files
------------

// File: rtl/move_request_gen.sv
// rtl/move_request_gen.sv - debounced push-button to grid-move request initiator for an 8x8 board.
// Define DIAGONAL_EN to allow one vertical plus one horizontal bit as a diagonal request.
module move_request_gen #(
  parameter int COORD_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESP_TIMEOUT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               load_en,
  input  logic [COORD_W-1:0] load_i,
  input  logic [COORD_W-1:0] load_j,
  input  logic [COORD_W-1:0] inext,
  input  logic [COORD_W-1:0] jnext,
  input  logic               mov_valid,
  output logic               up,
  output logic               down,
  output logic               left,
  output logic               right,
  output logic [COORD_W-1:0] iactual,
  output logic [COORD_W-1:0] jactual,
  output logic               busy,
  output logic               rejected,
  output logic [7:0]         move_count
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t         state;
  logic [3:0]     raw, sync1, sync2, deb, deb_d1;
  logic [3:0]     rise, mask, dir;
  logic [1:0]     vert, horz;
  logic [DCW-1:0] dcnt [4];
  logic [TCW-1:0] tcnt;

  // Bit order throughout: [0]=up, [1]=down, [2]=left, [3]=right
  assign raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_d1 <= '0;
      for (int b = 0; b < 4; b++) dcnt[b] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      deb_d1 <= deb;
      for (int b = 0; b < 4; b++) begin
        if (sync2[b] == deb[b]) begin
          dcnt[b] <= '0;
        end else if (dcnt[b] == DCW'(DEBOUNCE_CYCLES)) begin
          deb[b]  <= ~deb[b];
          dcnt[b] <= '0;
        end else begin
          dcnt[b] <= dcnt[b] + DCW'(1);
        end
      end
    end
  end

  // Opposing presses cancel each other before any priority or diagonal decision
  always_comb begin
    rise = deb & ~deb_d1;
    vert = (rise[0] & rise[1]) ? 2'b00 : rise[1:0];
    horz = (rise[2] & rise[3]) ? 2'b00 : rise[3:2];
`ifdef DIAGONAL_EN
    mask = {horz, vert};
`else
    mask = 4'b0000;
    if (vert[0])      mask = 4'b0001;
    else if (vert[1]) mask = 4'b0010;
    else if (horz[0]) mask = 4'b0100;
    else if (horz[1]) mask = 4'b1000;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= '0;
      iactual    <= '0;
      jactual    <= '0;
      move_count <= '0;
      rejected   <= 1'b0;
      tcnt       <= '0;
    end else begin
      rejected <= 1'b0;
      if (load_en) begin
        iactual <= load_i;
        jactual <= load_j;
        dir     <= '0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (mask != 4'b0000) begin
              dir   <= mask;
              state <= REQ;
            end
          end
          REQ: begin
            tcnt  <= '0;
            state <= WAIT;
          end
          WAIT: begin
            // A response arriving on the timeout cycle still counts as accepted
            if (mov_valid) begin
              iactual <= inext;
              jactual <= jnext;
              if (move_count != 8'hFF) move_count <= move_count + 8'd1;
              dir     <= '0;
              state   <= DONE;
            end else if (tcnt == TCW'(RESP_TIMEOUT - 1)) begin
              rejected <= 1'b1;
              dir      <= '0;
              state    <= DONE;
            end else begin
              tcnt <= tcnt + TCW'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign {right, left, down, up} = dir;
  assign busy = (state != IDLE);

endmodule
